// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the MxC result-RAM sequencers (writer and reader).
//   DIM, DATA_W, LOG2_DIM, ADDR_W, N : default matrix geometry
//   mat_state_e                      : 2-bit sequencer state encoding
// ---------------------------------------------------------------------------
package matrix_pkg;

    localparam int DIM      = 4;
    localparam int DATA_W   = 16;
    localparam int LOG2_DIM = $clog2(DIM);
    localparam int ADDR_W   = 2 * LOG2_DIM;
    localparam int N        = DIM * DIM;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mat_state_e;

endpackage

// File: rtl/matrix_unload_ctrl_if.sv
// ---------------------------------------------------------------------------
// matrix_unload_ctrl_if
// Control, RAM-read and output-stream signals of the MxC unload sequencer.
//   master : sequencer side (drives busy/done, RAM read, stream beat)
//   slave  : environment side (drives start, RAM data, stream ready)
// ---------------------------------------------------------------------------
interface matrix_unload_ctrl_if #(
    parameter int DATA_W = matrix_pkg::DATA_W,
    parameter int ADDR_W = matrix_pkg::ADDR_W
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;

    modport master (
        input  start, mem_rdata, out_ready,
        output busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        output start, mem_rdata, out_ready,
        input  busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/matrix_unload_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// mat_skid_fifo2
// Two-entry FIFO holding returned RAM words until the consumer takes them.
//   clk, rst : clock, synchronous active-high reset (clears storage too)
//   push     : write wdata (accepted when not full, or full with pop)
//   pop      : drop head (ignored when empty)
//   rdata    : head entry
//   full, empty, count : occupancy
// ---------------------------------------------------------------------------
module mat_skid_fifo2 #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);
    logic [W-1:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (cnt != 2'd0);
    // When full, a simultaneous pop frees the head slot, which is exactly
    // where wr_ptr points, so the incoming word can land there.
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= wdata;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = slot[rd_ptr];
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign count = cnt;
endmodule

// File: rtl/matrix_unload_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_unload_ctrl
// Walks all DIM*DIM addresses of the MxC result RAM and streams the elements
// out over valid/ready, absorbing backpressure with a 2-entry buffer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/busy/done, RAM read port (mem_rd_en, mem_addr, mem_rdata
//              one cycle later), stream (out_valid/ready/data/idx/last)
// COL_MAJOR=1 swaps the row/column halves of the beat index to form the
// RAM address; out_idx always counts beats in stream order.
// ---------------------------------------------------------------------------
module matrix_unload_ctrl
    import matrix_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DIM       = 4,
    parameter int COL_MAJOR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    matrix_unload_ctrl_if.master   bus
);
    localparam int LOG2_DIM = $clog2(DIM);
    localparam int ADDR_W   = 2 * LOG2_DIM;
    localparam int N        = DIM * DIM;
    localparam int FW       = DATA_W + ADDR_W;

    localparam logic [ADDR_W:0]   N_K      = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]   LAST_K   = (ADDR_W+1)'(N - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    mat_state_e        state, state_nxt;
    logic [ADDR_W:0]   rd_k;          // reads issued, saturates at N
    logic [ADDR_W:0]   bt_k;          // beats accepted, saturates at N
    logic              rd_pend;       // read issued last cycle, data on mem_rdata now
    logic [ADDR_W-1:0] rd_pend_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic              hs;
    logic              credit;
    logic              issue;

    logic [FW-1:0]     fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_cnt;

    assign hs = bus.out_valid && bus.out_ready;

    // A read may issue while (buffered + in flight - popping now) < 2, so a
    // pop this cycle frees a slot and sustains one beat per cycle.
    assign credit = fifo_full ? (hs && !rd_pend)
                              : ((fifo_cnt == 2'd0) || !rd_pend || hs);
    assign issue  = (state == ST_RUN) && (rd_k < N_K) && credit;

    generate
        if (COL_MAJOR != 0) begin : g_col
            assign rd_addr = {rd_k[LOG2_DIM-1:0], rd_k[ADDR_W-1:LOG2_DIM]};
        end else begin : g_row
            assign rd_addr = rd_k[ADDR_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rd_k        <= '0;
            bt_k        <= '0;
            rd_pend     <= 1'b0;
            rd_pend_idx <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= issue;
            if (issue) rd_pend_idx <= rd_k[ADDR_W-1:0];
            if (state == ST_IDLE) begin
                rd_k <= '0;
                bt_k <= '0;
            end else begin
                if (issue) rd_k <= rd_k + 1'b1;
                if (hs && (bt_k != N_K)) bt_k <= bt_k + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_RUN;
            ST_RUN:   if (issue && (rd_k == LAST_K)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (hs && (bt_k == LAST_K)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    mat_skid_fifo2 #(.W(FW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pend),
        .wdata ({rd_pend_idx, bus.mem_rdata}),
        .pop   (hs),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = rd_addr;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head[DATA_W-1:0];
    assign bus.out_idx   = fifo_head[FW-1:DATA_W];
    assign bus.out_last  = !fifo_empty && (fifo_head[FW-1:DATA_W] == LAST_IDX);
endmodule
